// File: rtl/fractal_sync_age_sched.sv
// Drains IN_PORTS input FIFOs into one registered valid/ready output.
// Fixed priority (lowest index first), with per-input aging and an urgent round-robin path.
module fractal_sync_age_sched #(
  parameter int unsigned IN_PORTS  = 4,
  parameter type         arbiter_t = logic,
  parameter int unsigned AGE_W     = 4,
  parameter int unsigned AGE_LIMIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [IN_PORTS-1:0] empty_i,
  input  arbiter_t            element_i [IN_PORTS],
  output logic [IN_PORTS-1:0] pop_o,
  output logic                valid_o,
  input  logic                ready_i,
  output arbiter_t            element_o,
  output logic                urgent_o
);

  localparam int unsigned      IDX_W   = (IN_PORTS > 1) ? $clog2(IN_PORTS) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(IN_PORTS - 1);

  logic [AGE_W-1:0]    age_q [IN_PORTS];
  logic [AGE_W-1:0]    age_d [IN_PORTS];
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                valid_q, valid_d;
  arbiter_t            element_q, element_d;

  logic                load;
  logic                grant;
  logic                any_urgent;
  logic [IN_PORTS-1:0] urg_vec;
  logic                urg_found;
  logic [IDX_W-1:0]    urg_idx;
  logic                pri_found;
  logic [IDX_W-1:0]    pri_idx;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    winner;

  // Winner selection: urgent inputs by RR from ptr_q, else lowest non-empty index
  always_comb begin
    load       = enable_i & (~valid_q | ready_i);
    urg_found  = 1'b0;
    urg_idx    = '0;
    pri_found  = 1'b0;
    pri_idx    = '0;
    cand       = '0;
    for (int i = 0; i < IN_PORTS; i++) begin
      urg_vec[i] = ~empty_i[i] & (age_q[i] >= AGE_LIM);
    end
    any_urgent = |urg_vec;
    for (int unsigned off = 0; off < IN_PORTS; off++) begin
      cand = IDX_W'((32'(ptr_q) + off) % IN_PORTS);
      if (!urg_found && urg_vec[cand]) begin
        urg_found = 1'b1;
        urg_idx   = cand;
      end
    end
    for (int i = 0; i < IN_PORTS; i++) begin
      if (!pri_found && !empty_i[i]) begin
        pri_found = 1'b1;
        pri_idx   = IDX_W'(i);
      end
    end
    winner   = any_urgent ? urg_idx : pri_idx;
    grant    = ~rst_i & load & pri_found;
    urgent_o = grant & any_urgent;
    for (int i = 0; i < IN_PORTS; i++) begin
      pop_o[i] = grant && (winner == IDX_W'(i));
    end
  end

  // Next-state: output register, RR pointer and age counters
  always_comb begin
    valid_d   = valid_q;
    element_d = element_q;
    ptr_d     = ptr_q;
    if (grant) begin
      valid_d   = 1'b1;
      element_d = element_i[winner];
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (grant && any_urgent) begin
      ptr_d = (winner == IDX_END) ? '0 : winner + IDX_W'(1);
    end
    for (int i = 0; i < IN_PORTS; i++) begin
      if (empty_i[i] || (grant && (winner == IDX_W'(i)))) begin
        age_d[i] = '0;
      end else if (grant) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + AGE_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      element_q <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < IN_PORTS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      element_q <= element_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < IN_PORTS; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end

  assign valid_o   = valid_q;
  assign element_o = element_q;

endmodule

// File: tb/tb_fractal_sync_age_sched.sv
// Scoreboard bench for fractal_sync_age_sched: directed phases then random traffic,
// checked against a queue/array reference model of the scheduling rules.
module tb_fractal_sync_age_sched;

  localparam int N       = 4;
  localparam int AGE_W   = 2;
  localparam int LIMIT   = 3;
  localparam int AGE_TOP = (1 << AGE_W) - 1;
  localparam int N_RAND  = 3000;

  typedef logic [7:0] elem_t;

  typedef struct {
    logic [N-1:0] pop;
    logic         urg;
    logic         valid;
    elem_t        elem;
    bit           chk_out;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         enable_i = 1'b0;
  logic [N-1:0] empty_i = '1;
  elem_t        element_i [N];
  logic [N-1:0] pop_o;
  logic         valid_o;
  logic         ready_i = 1'b0;
  elem_t        element_o;
  logic         urgent_o;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  // reference model state
  int    m_age [N];
  int    m_ptr   = 0;
  bit    m_valid = 1'b0;
  elem_t m_elem  = '0;

  always #5 clk = ~clk;

  fractal_sync_age_sched #(
    .IN_PORTS (N),
    .arbiter_t(elem_t),
    .AGE_W    (AGE_W),
    .AGE_LIMIT(LIMIT)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .empty_i  (empty_i),
    .element_i(element_i),
    .pop_o    (pop_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .element_o(element_o),
    .urgent_o (urgent_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs and advance the model.
  task automatic drive_cycle(input bit rst, input bit en, input logic [N-1:0] emp,
                             input bit rdy, input bit chk_out);
    exp_t e;
    int   win;
    bit   urg;
    bit   load;
    rst_i    = rst;
    enable_i = en;
    empty_i  = emp;
    ready_i  = rdy;
    for (int i = 0; i < N; i++) element_i[i] = elem_t'($urandom);
    e.pop     = '0;
    e.urg     = 1'b0;
    e.valid   = m_valid;
    e.elem    = m_elem;
    e.chk_out = chk_out;
    win = -1;
    urg = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_elem  = '0;
      m_ptr   = 0;
      for (int i = 0; i < N; i++) m_age[i] = 0;
    end else begin
      load = en && (!m_valid || rdy);
      if (load) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (win < 0 && !emp[j] && m_age[j] >= LIMIT) begin
            win = j;
            urg = 1'b1;
          end
        end
        for (int j = 0; j < N; j++) begin
          if (win < 0 && !emp[j]) win = j;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (emp[i] || i == win) m_age[i] = 0;
        else if (win >= 0)      m_age[i] = (m_age[i] + 1 > AGE_TOP) ? AGE_TOP : m_age[i] + 1;
      end
      if (win >= 0) begin
        e.pop[win] = 1'b1;
        e.urg      = urg;
        if (urg) m_ptr = (win + 1) % N;
        m_valid = 1'b1;
        m_elem  = element_i[win];
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the queued prediction mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pop_o", 32'(pop_o), 32'(e.pop));
        check("urgent_o", 32'(urgent_o), 32'(e.urg));
        if (e.chk_out) begin
          check("valid_o", 32'(valid_o), 32'(e.valid));
          check("element_o", 32'(element_o), 32'(e.elem));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] emp;
    for (int i = 0; i < N; i++) begin
      element_i[i] = '0;
      m_age[i]     = 0;
    end
    @(posedge clk);
    #1;
    // reset with all inputs non-empty
    drive_cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    // fixed priority: inputs 1 and 2 non-empty
    for (int c = 0; c < 10; c++) drive_cycle(1'b0, 1'b1, 4'b1001, 1'b1, 1'b1);
    // aging: inputs 0 and 3 non-empty
    for (int c = 0; c < 16; c++) drive_cycle(1'b0, 1'b1, 4'b0110, 1'b1, 1'b1);
    // backpressure then release
    for (int c = 0; c < 5; c++)  drive_cycle(1'b0, 1'b1, 4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++)  drive_cycle(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
    // enable low with a held element
    for (int c = 0; c < 4; c++)  drive_cycle(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    // reset while holding an element
    for (int c = 0; c < 3; c++)  drive_cycle(1'b0, 1'b1, 4'b0100, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'b0000, 1'b0, 1'b1);
    drive_cycle(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
    // random traffic
    for (int c = 0; c < N_RAND; c++) begin
      for (int i = 0; i < N; i++) emp[i] = ($urandom_range(0, 3) == 0);
      drive_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 7) != 0, emp,
                  $urandom_range(0, 3) != 0, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
